// File: rtl/vote_session_ctrl.sv
// vote_session_ctrl: one-ballot-per-voter session with timeout and one-hot majority verdict
module vote_session_ctrl #(
    parameter int N_VOTERS = 4,
    parameter int TIMEOUT = 16,
    parameter int CNT_W = $clog2(N_VOTERS + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [N_VOTERS-1:0] vote_valid,
    input  logic [N_VOTERS-1:0] vote_yes,
    output logic                busy,
    output logic [N_VOTERS-1:0] voted_mask,
    output logic [CNT_W-1:0]    yes_count,
    output logic                result_valid,
    output logic [2:0]          result,
    output logic                timed_out
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int CW1 = CNT_W + 1;
    localparam logic [CNT_W:0] NV = CW1'(N_VOTERS);
    typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;
    state_t state, state_nx;
    logic [TW-1:0] timer;
    logic [N_VOTERS-1:0] accept, mask_nx;
    logic [CNT_W-1:0] add, yes_nx;
    logic [CNT_W:0] twice_y;
    logic [2:0] verdict;
    logic close;
    always_comb begin
        accept = vote_valid & ~voted_mask;
        mask_nx = voted_mask | accept;
        add = '0;
        for (int i = 0; i < N_VOTERS; i++) add = add + CNT_W'(accept[i] & vote_yes[i]);
        yes_nx = yes_count + add;
        twice_y = {yes_nx, 1'b0};
        verdict = twice_y < NV ? 3'b100 : twice_y == NV ? 3'b010 : 3'b001;
        close = &mask_nx || timer == TW'(TIMEOUT - 1);
    end
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end
    always_comb begin
        state_nx = state == IDLE ? (start ? COLLECT : IDLE) :
                   state == COLLECT ? (close ? DONE : COLLECT) : IDLE;
    end
    always_comb begin
        busy = state != IDLE;
        result_valid = state == DONE;
    end
    always_ff @(posedge clk) begin
        if (rst || (state == IDLE && start)) begin
            voted_mask <= '0;
            yes_count <= '0;
            timer <= '0;
            result <= 3'b000;
            timed_out <= 1'b0;
        end else if (state == COLLECT) begin
            voted_mask <= mask_nx;
            yes_count <= yes_nx;
            timer <= timer + TW'(1);
            if (close) begin
                result <= verdict;
                timed_out <= ~&mask_nx;
            end
        end
    end
endmodule

// File: tb/tb_vote_session_ctrl.sv
// tb_vote_session_ctrl: directed vector table plus multi-cycle sequences for vote_session_ctrl
module tb_vote_session_ctrl;
    logic clk = 1'b0;
    logic rst, start;
    logic [3:0] vv, vy, mask;
    logic [2:0] yes, res;
    logic busy, rv, to;
    logic start5;
    logic [4:0] vv5, vy5, mask5;
    logic [2:0] yes5, res5;
    logic busy5, rv5, to5;
    int tests = 0;
    int fails = 0;
    typedef struct packed {
        logic       r;
        logic       s;
        logic [3:0] v;
        logic [3:0] y;
        logic       e_busy;
        logic [3:0] e_mask;
        logic [2:0] e_yes;
        logic       e_rv;
        logic [2:0] e_res;
        logic       e_to;
    } vec_t;
    vec_t tbl [18];
    always #5 clk = ~clk;
    vote_session_ctrl #(.N_VOTERS(4), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .start(start), .vote_valid(vv), .vote_yes(vy),
        .busy(busy), .voted_mask(mask), .yes_count(yes), .result_valid(rv),
        .result(res), .timed_out(to)
    );
    vote_session_ctrl #(.N_VOTERS(5), .TIMEOUT(16)) dut5 (
        .clk(clk), .rst(rst), .start(start5), .vote_valid(vv5), .vote_yes(vy5),
        .busy(busy5), .voted_mask(mask5), .yes_count(yes5), .result_valid(rv5),
        .result(res5), .timed_out(to5)
    );
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic step(input logic r, input logic s, input logic [3:0] v, input logic [3:0] y);
        rst = r;
        start = s;
        vv = v;
        vy = y;
        @(posedge clk);
        #1;
    endtask
    function automatic logic [31:0] pack4();
        return 32'({busy, mask, yes, rv, res, to});
    endfunction
    initial begin
        rst = 1'b1; start = 1'b0; vv = '0; vy = '0;
        start5 = 1'b0; vv5 = '0; vy5 = '0;
        // reset with garbage inputs, idle ballots ignored, sequential turnout pass
        tbl[0]  = '{1'b1, 1'b1, 4'b1111, 4'b1010, 1'b0, 4'b0000, 3'd0, 1'b0, 3'b000, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 4'b0101, 4'b1111, 1'b0, 4'b0000, 3'd0, 1'b0, 3'b000, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 4'b1111, 4'b1111, 1'b0, 4'b0000, 3'd0, 1'b0, 3'b000, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 4'b0000, 4'b0000, 1'b1, 4'b0000, 3'd0, 1'b0, 3'b000, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 4'b0001, 4'b0001, 1'b1, 4'b0001, 3'd1, 1'b0, 3'b000, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 4'b0010, 4'b0010, 1'b1, 4'b0011, 3'd2, 1'b0, 3'b000, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 4'b0100, 4'b0100, 1'b1, 4'b0111, 3'd3, 1'b0, 3'b000, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 4'b1000, 4'b0000, 1'b1, 4'b1111, 3'd3, 1'b1, 3'b001, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 4'b1111, 3'd3, 1'b0, 3'b001, 1'b0};
        // start with ballots in IDLE, simultaneous tie, start in DONE ignored
        tbl[9]  = '{1'b0, 1'b1, 4'b1111, 4'b1111, 1'b1, 4'b0000, 3'd0, 1'b0, 3'b000, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 4'b1111, 4'b0011, 1'b1, 4'b1111, 3'd2, 1'b1, 3'b010, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 4'b1111, 4'b1111, 1'b0, 4'b1111, 3'd2, 1'b0, 3'b010, 1'b0};
        // repeat ballots and start pulses in COLLECT
        tbl[12] = '{1'b0, 1'b1, 4'b0000, 4'b0000, 1'b1, 4'b0000, 3'd0, 1'b0, 3'b000, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 4'b0010, 4'b0010, 1'b1, 4'b0010, 3'd1, 1'b0, 3'b000, 1'b0};
        tbl[14] = '{1'b0, 1'b1, 4'b0010, 4'b0000, 1'b1, 4'b0010, 3'd1, 1'b0, 3'b000, 1'b0};
        tbl[15] = '{1'b0, 1'b1, 4'b0010, 4'b0010, 1'b1, 4'b0010, 3'd1, 1'b0, 3'b000, 1'b0};
        tbl[16] = '{1'b0, 1'b0, 4'b1101, 4'b0000, 1'b1, 4'b1111, 3'd1, 1'b1, 3'b100, 1'b0};
        tbl[17] = '{1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 4'b1111, 3'd1, 1'b0, 3'b100, 1'b0};
        for (int i = 0; i < 18; i++) begin
            step(tbl[i].r, tbl[i].s, tbl[i].v, tbl[i].y);
            chk($sformatf("vec%0d", i), pack4(),
                32'({tbl[i].e_busy, tbl[i].e_mask, tbl[i].e_yes, tbl[i].e_rv, tbl[i].e_res, tbl[i].e_to}));
        end
        chk("n5_reset", 32'({busy5, mask5, yes5, rv5, res5, to5}), 32'd0);
        // timeout with a repeat ballot and a start pulse mid-session
        step(1'b0, 1'b1, 4'b0000, 4'b0000);
        step(1'b0, 1'b0, 4'b0001, 4'b0001);
        chk("to_first", pack4(), 32'({1'b1, 4'b0001, 3'd1, 1'b0, 3'b000, 1'b0}));
        step(1'b0, 1'b1, 4'b0001, 4'b0000);
        chk("to_dup", pack4(), 32'({1'b1, 4'b0001, 3'd1, 1'b0, 3'b000, 1'b0}));
        for (int k = 3; k <= 16; k++) begin
            step(1'b0, k == 8, 4'b0000, 4'b0000);
            if (k < 16) chk($sformatf("to_wait%0d", k), 32'({busy, rv}), 32'b10);
            else chk("to_close", pack4(), 32'({1'b1, 4'b0001, 3'd1, 1'b1, 3'b100, 1'b1}));
        end
        step(1'b0, 1'b0, 4'b0000, 4'b0000);
        chk("to_idle", pack4(), 32'({1'b0, 4'b0001, 3'd1, 1'b0, 3'b100, 1'b1}));
        // full turnout in the last timer cycle is not a timeout
        step(1'b0, 1'b1, 4'b0000, 4'b0000);
        for (int k = 1; k <= 15; k++) step(1'b0, 1'b0, 4'b0000, 4'b0000);
        chk("last_open", 32'({busy, rv}), 32'b10);
        step(1'b0, 1'b0, 4'b1111, 4'b1100);
        chk("last_full", pack4(), 32'({1'b1, 4'b1111, 3'd2, 1'b1, 3'b010, 1'b0}));
        step(1'b0, 1'b0, 4'b0000, 4'b0000);
        // abort by reset mid-session, then a clean session
        step(1'b0, 1'b1, 4'b0000, 4'b0000);
        step(1'b0, 1'b0, 4'b0011, 4'b0011);
        chk("mid_mask", pack4(), 32'({1'b1, 4'b0011, 3'd2, 1'b0, 3'b000, 1'b0}));
        step(1'b1, 1'b0, 4'b1111, 4'b1111);
        chk("mid_rst", pack4(), 32'd0);
        step(1'b0, 1'b1, 4'b0000, 4'b0000);
        chk("mid_restart", pack4(), 32'({1'b1, 4'b0000, 3'd0, 1'b0, 3'b000, 1'b0}));
        step(1'b0, 1'b0, 4'b1111, 4'b1111);
        chk("mid_clean", pack4(), 32'({1'b1, 4'b1111, 3'd4, 1'b1, 3'b001, 1'b0}));
        step(1'b0, 1'b0, 4'b0000, 4'b0000);
        // five voters: 2 yes rejects, 3 yes passes
        start5 = 1'b1;
        step(1'b0, 1'b0, 4'b0000, 4'b0000);
        start5 = 1'b0; vv5 = 5'b11111; vy5 = 5'b00011;
        step(1'b0, 1'b0, 4'b0000, 4'b0000);
        chk("n5_two", 32'({rv5, res5, yes5, to5}), 32'({1'b1, 3'b100, 3'd2, 1'b0}));
        vv5 = '0; vy5 = '0;
        step(1'b0, 1'b0, 4'b0000, 4'b0000);
        start5 = 1'b1;
        step(1'b0, 1'b0, 4'b0000, 4'b0000);
        start5 = 1'b0; vv5 = 5'b11111; vy5 = 5'b10101;
        step(1'b0, 1'b0, 4'b0000, 4'b0000);
        chk("n5_three", 32'({rv5, res5, yes5, to5}), 32'({1'b1, 3'b001, 3'd3, 1'b0}));
        vv5 = '0; vy5 = '0;
        step(1'b0, 1'b0, 4'b0000, 4'b0000);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/vote_session_ctrl.md
Name: vote_session_ctrl

Overview:
- Parametrised, clocked successor to the 4-voter combinational majority decoder.
- Runs a voting session: opens on start, collects at most one ballot per voter, and closes when all voters have voted or a timeout expires.
- Publishes a registered one-hot verdict (reject/tie/pass) with a one-cycle valid pulse.
- Sits between voter input logic and the result display/latch.

Parameters:
- N_VOTERS, 4, number of voters (>=2).
- TIMEOUT, 16, maximum COLLECT duration in cycles (>=1).
- CNT_W, $clog2(N_VOTERS+1), width of the tally counters.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  open a session; honoured only in IDLE.
- vote_valid  input  N_VOTERS  per-voter ballot strobe.
- vote_yes  input  N_VOTERS  per-voter ballot value (1 = yes); sampled only with its vote_valid bit.
- busy  output  1  high in COLLECT and DONE.
- voted_mask  output  N_VOTERS  voters whose ballot has been accepted this session.
- yes_count  output  CNT_W  accepted yes ballots.
- result_valid  output  1  one-cycle pulse when the verdict is final.
- result  output  3  one-hot verdict: 100 = reject, 010 = tie, 001 = pass.
- timed_out  output  1  session closed by timeout, not by full turnout.

Behaviour:
- Reset: synchronous, active-high, clk only.
  - Outputs on reset: state=IDLE; busy=0, voted_mask=0, yes_count=0, result_valid=0, result=000, timed_out=0; timer=0.
  - rst during any state overrides all other activity and aborts any session.
- States: IDLE, COLLECT, DONE.
- IDLE:
  - start=1 -> COLLECT; clear voted_mask, yes_count, timer, result (to 000) and timed_out.
  - Ballots are ignored in IDLE.
- COLLECT (timer counts 0 .. TIMEOUT-1, one per cycle):
  - Bit i is accepted iff vote_valid[i]=1 and voted_mask[i]=0.
  - On accept: set voted_mask[i]; if vote_yes[i]=1, increment yes_count.
  - Several voters may be accepted in the same cycle; yes_count adds the popcount of the accepted yes bits.
  - Repeat ballots from a voter are ignored silently; the first ballot stands.
  - start in COLLECT is ignored.
  - Close condition: (voted_mask | accepted bits) == all ones, or timer == TIMEOUT-1.
  - Ballots presented in the closing cycle are counted.
  - On close -> DONE. result, yes_count and timed_out are registered from the final tally on that edge.
  - timed_out=1 only if turnout was not full at close. Full turnout in the last timer cycle gives timed_out=0.
- Verdict, with Y = final yes_count and N = N_VOTERS:
  - 2Y < N -> 100 (reject).
  - 2Y == N -> 010 (tie).
  - 2Y > N -> 001 (pass).
  - Voters absent at close count as no.
  - Odd N can never produce 010.
  - For N=4 this reproduces the original table: 0–1 yes -> 100, 2 -> 010, 3–4 -> 001.
- DONE:
  - Lasts exactly one cycle with result_valid=1, then -> IDLE unconditionally.
  - start and ballots are ignored in DONE.
- Holding of outputs:
  - result, yes_count, voted_mask and timed_out hold after DONE until the next accepted start.
  - result_valid=0 outside DONE.
- Latency:
  - Closing ballot in cycle k -> result_valid in cycle k+1.
  - Minimum start-to-result latency: start seen at edge 0, COLLECT at cycle 1, all ballots at cycle 1, DONE at cycle 2.
- Width rule: yes_count never exceeds N_VOTERS, so there is no wrap.

Test Plan:
- Reset: assert rst 2 cycles with random inputs -> busy=0, result=000, result_valid=0, voted_mask=0, yes_count=0, timed_out=0.
- N=4 sequential turnout: start; voters 0,1,2 yes on COLLECT cycles 1,2,3; voter 3 no on cycle 4 -> result_valid in cycle 5, result=001, yes_count=3, voted_mask=1111, timed_out=0; IDLE next cycle.
- Simultaneous tie: start; one cycle with vote_valid=1111, vote_yes=0011 -> next cycle result_valid=1, result=010, yes_count=2.
- Timeout: TIMEOUT=16; only voter 0 votes yes -> COLLECT occupies 16 cycles, result_valid on cycle 17 after start, result=100, yes_count=1, voted_mask=0001, timed_out=1.
- Duplicate and ignored inputs: voter 1 yes, then voter 1 again with no, plus start pulses during COLLECT -> yes_count stays 1 for voter 1, session not restarted, timer unaffected.
- Mid-session reset: rst in COLLECT with voted_mask=0011 -> next cycle IDLE, all outputs at reset values; a new start runs a clean session. Also run with N_VOTERS=5: 2 yes -> 100, 3 yes -> 001.
